// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port line arbiter in front of the data memory.
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DATA_W = 256;

endpackage

// File: rtl/arb_rr2.sv
// Combinational 2-way picker: round-robin tie-break, or port 1 always wins when FIXED_PRIO is set.
module arb_rr2
  import mem_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = PORT_I;
    unique case (req)
      2'b01:   gnt_idx = PORT_I;
      2'b10:   gnt_idx = PORT_D;
      2'b11:   gnt_idx = FIXED_PRIO ? PORT_D : ~last_grant;
      default: gnt_idx = PORT_I;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one line-wide data memory between the I-cache (port 0) and D-cache (port 1),
// one whole-line transaction at a time; the grant is held until the memory acknowledges.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              m0_enable_i,
  input  logic              m0_write_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [DATA_W-1:0] m0_data_i,
  output logic              m0_ack_o,
  output logic [DATA_W-1:0] m0_data_o,
  input  logic              m1_enable_i,
  input  logic              m1_write_i,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [DATA_W-1:0] m1_data_i,
  output logic              m1_ack_o,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_data_i
);

  state_t state, state_nxt;
  logic   owner, last_grant;
  logic   gnt_valid, gnt_idx;
  logic   grant, done;

  arb_rr2 #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req        ({m1_enable_i, m0_enable_i}),
    .last_grant (last_grant),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx)
  );

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE: if (gnt_valid) begin
        state_nxt = BUSY;
        grant     = 1'b1;
      end
      BUSY: if (mem_ack_i) begin
        state_nxt = IDLE;
        done      = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      owner        <= PORT_I;
      last_grant   <= PORT_D;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        owner        <= gnt_idx;
        last_grant   <= gnt_idx;
        mem_enable_o <= 1'b1;
        mem_write_o  <= (gnt_idx == PORT_D) ? m1_write_i : m0_write_i;
        mem_addr_o   <= (gnt_idx == PORT_D) ? m1_addr_i  : m0_addr_i;
        mem_data_o   <= (gnt_idx == PORT_D) ? m1_data_i  : m0_data_i;
      end else if (done) begin
        // addr/data intentionally keep their last values after completion
        mem_enable_o <= 1'b0;
        mem_write_o  <= 1'b0;
      end
    end
  end

  always_comb begin
    m0_ack_o  = done && (owner == PORT_I);
    m1_ack_o  = done && (owner == PORT_D);
    m0_data_o = mem_data_i;
    m1_data_o = mem_data_i;
  end

endmodule
